// File: rtl/kernel_window_addrgen.sv
// K x K kernel window address generator: scans every centre pixel of a
// runtime-sized frame in row-major order and emits one neighbourhood tap per
// handshake, clamping out-of-frame coordinates and optionally flagging them
// for zero substitution.
`timescale 1ns/1ps
module kernel_window_addrgen #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned KSIZE  = 3,
    parameter int unsigned KIDX_W = (KSIZE * KSIZE > 1) ? $clog2(KSIZE * KSIZE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] img_width,
    input  logic [ADDR_W-1:0] img_depth,
    input  logic              mode,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_col,
    output logic [ADDR_W-1:0] out_row,
    output logic [KIDX_W-1:0] out_kidx,
    output logic              out_pad,
    output logic              out_last_tap,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned R  = (KSIZE - 1) / 2;
    localparam int unsigned KW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    // Signed working width: holds ctr + offset - R without wrapping
    localparam int unsigned SW = ADDR_W + KW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Latched frame configuration
    logic [ADDR_W-1:0] width_q, width_d;
    logic [ADDR_W-1:0] depth_q, depth_d;
    logic              mode_q,  mode_d;

    // Position of the tap currently presented (centre and kernel offsets)
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [KW-1:0]     ky_q,  ky_d;
    logic [KW-1:0]     kx_q,  kx_d;

    // Registered outputs
    logic              valid_q,    valid_d;
    logic [ADDR_W-1:0] ocol_q,     ocol_d;
    logic [ADDR_W-1:0] orow_q,     orow_d;
    logic [KIDX_W-1:0] kidx_q,     kidx_d;
    logic              pad_q,      pad_d;
    logic              last_tap_q, last_tap_d;
    logic              last_q,     last_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    // Tap helpers for the next presented tap
    logic [ADDR_W:0]   col_res_c;
    logic [ADDR_W:0]   row_res_c;
    logic              tap_last_c;

    // Resolve one axis: returns {out_of_range, clamped_coordinate}
    function automatic logic [ADDR_W:0] axis_tap(
        input logic [ADDR_W-1:0] ctr,
        input logic [KW-1:0]     k,
        input logic [ADDR_W-1:0] dim
    );
        logic signed [SW-1:0] raw;
        logic signed [SW-1:0] hi;
        logic [ADDR_W:0]      res;
        raw = $signed(SW'(ctr)) + $signed(SW'(k)) - $signed(SW'(R));
        hi  = $signed(SW'(dim)) - $signed(SW'(1));
        if (raw < $signed(SW'(0))) begin
            res = {1'b1, {ADDR_W{1'b0}}};
        end else if (raw > hi) begin
            res = {1'b1, dim - ADDR_W'(1)};
        end else begin
            res = {1'b0, raw[ADDR_W-1:0]};
        end
        return res;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (img_width == '0 || img_depth == '0) ? S_FIN : S_SCAN;
                end
            end
            S_SCAN: begin
                if (valid_q && out_ready && last_q) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counter advance and next registered output values
    always_comb begin
        width_d = width_q;
        depth_d = depth_q;
        mode_d  = mode_q;
        row_d   = row_q;
        col_d   = col_q;
        ky_d    = ky_q;
        kx_d    = kx_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    width_d = img_width;
                    depth_d = img_depth;
                    mode_d  = mode;
                    row_d   = '0;
                    col_d   = '0;
                    ky_d    = '0;
                    kx_d    = '0;
                end
            end
            S_SCAN: begin
                if (valid_q && out_ready && !last_q) begin
                    if (kx_q == KW'(KSIZE - 1)) begin
                        kx_d = '0;
                        if (ky_q == KW'(KSIZE - 1)) begin
                            ky_d = '0;
                            if (col_q == width_q - ADDR_W'(1)) begin
                                col_d = '0;
                                row_d = row_q + ADDR_W'(1);
                            end else begin
                                col_d = col_q + ADDR_W'(1);
                            end
                        end else begin
                            ky_d = ky_q + KW'(1);
                        end
                    end else begin
                        kx_d = kx_q + KW'(1);
                    end
                end
            end
            default: ;
        endcase

        col_res_c  = axis_tap(col_d, kx_d, width_d);
        row_res_c  = axis_tap(row_d, ky_d, depth_d);
        tap_last_c = (ky_d == KW'(KSIZE - 1)) && (kx_d == KW'(KSIZE - 1));

        valid_d    = 1'b0;
        ocol_d     = '0;
        orow_d     = '0;
        kidx_d     = '0;
        pad_d      = 1'b0;
        last_tap_d = 1'b0;
        last_d     = 1'b0;
        if (state_d == S_SCAN) begin
            valid_d    = 1'b1;
            ocol_d     = col_res_c[ADDR_W-1:0];
            orow_d     = row_res_c[ADDR_W-1:0];
            kidx_d     = KIDX_W'(ky_d) * KIDX_W'(KSIZE) + KIDX_W'(kx_d);
            pad_d      = mode_d && (col_res_c[ADDR_W] || row_res_c[ADDR_W]);
            last_tap_d = tap_last_c;
            last_d     = tap_last_c && (col_d == width_d - ADDR_W'(1))
                                    && (row_d == depth_d - ADDR_W'(1));
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            width_q    <= '0;
            depth_q    <= '0;
            mode_q     <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            ky_q       <= '0;
            kx_q       <= '0;
            valid_q    <= 1'b0;
            ocol_q     <= '0;
            orow_q     <= '0;
            kidx_q     <= '0;
            pad_q      <= 1'b0;
            last_tap_q <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            width_q    <= width_d;
            depth_q    <= depth_d;
            mode_q     <= mode_d;
            row_q      <= row_d;
            col_q      <= col_d;
            ky_q       <= ky_d;
            kx_q       <= kx_d;
            valid_q    <= valid_d;
            ocol_q     <= ocol_d;
            orow_q     <= orow_d;
            kidx_q     <= kidx_d;
            pad_q      <= pad_d;
            last_tap_q <= last_tap_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_col      = ocol_q;
    assign out_row      = orow_q;
    assign out_kidx     = kidx_q;
    assign out_pad      = pad_q;
    assign out_last_tap = last_tap_q;
    assign out_last     = last_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
